// File: rtl/ibex_csr_responder_pkg.sv
// Shared types, CSR constants and the read-modify-write helper for the
// ibex_csr_responder CSR endpoint.
package ibex_csr_responder_pkg;

  // CSR op encoding, matching ibex_pkg::csr_op_e.
  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // CSR address type, matching ibex_pkg::csr_num_e.
  typedef logic [11:0] csr_num_e;

  localparam csr_num_e CSR_MCYCLE  = 12'hB00;
  localparam csr_num_e CSR_MCYCLEH = 12'hB80;

  // Response-side FSM states.
  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_RESP = 1'b1
  } rsp_state_e;

  // True for op encodings this responder understands.
  function automatic logic csr_op_defined(input csr_op_e op);
    logic ok;
    case (op)
      CSR_OP_READ, CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // New CSR value after applying op to old with operand wdata.
  function automatic logic [31:0] csr_rmw(input logic [31:0] old,
                                          input logic [31:0] wdata,
                                          input csr_op_e     op);
    logic [31:0] nv;
    case (op)
      CSR_OP_WRITE: nv = wdata;
      CSR_OP_SET:   nv = old | wdata;
      CSR_OP_CLEAR: nv = old & ~wdata;
      default:      nv = old;
    endcase
    return nv;
  endfunction

endpackage

// File: rtl/ibex_csr_responder_cnt.sv
// 64-bit free-running cycle counter with per-word write enables.
// Only instantiated when IBEX_CSR_RESPONDER_CYCLE_CNT_EN is defined.
// A word write replaces the increment for that cycle; the other word holds.
module ibex_csr_responder_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  // Next count: increment with carry, or load the written word.
  always_comb begin
    cnt_d = cnt_q + 64'd1;
    if (we_lo_i) begin
      cnt_d = {cnt_q[63:32], wdata_i};
    end else if (we_hi_i) begin
      cnt_d = {wdata_i, cnt_q[31:0]};
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_csr_responder.sv
// CSR endpoint: accepts one CSR request per cycle, returns the pre-update
// value one cycle later and commits the update in the acceptance cycle.
// Backs NumScratch scratch CSRs at BaseAddr. Defining
// IBEX_CSR_RESPONDER_CYCLE_CNT_EN adds a RW 64-bit cycle counter at
// mcycle/mcycleh; otherwise those addresses decode as illegal.
module ibex_csr_responder
  import ibex_csr_responder_pkg::*;
#(
  parameter logic [11:0] BaseAddr      = 12'h7C0,
  parameter int          NumScratch    = 4,
  parameter logic [31:0] ScratchRstVal = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [11:0] req_addr_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o
);

  rsp_state_e state_q, state_d;

  logic [NumScratch-1:0][31:0] scratch_q, scratch_d;
  logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_illegal_q, rsp_illegal_d;

  csr_op_e     op;
  logic        accept;
  logic [11:0] win_off;
  logic        in_win;
  logic        hit;
  logic        ro_viol;
  logic        legal;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        do_write;

  assign op      = csr_op_e'(req_op_i);
  assign accept  = req_valid_i & req_ready_o;
  // Wrapping subtraction: addresses below BaseAddr land far outside the window.
  assign win_off = req_addr_i - BaseAddr;
  assign in_win  = ({20'd0, win_off} < 32'(NumScratch));

`ifdef IBEX_CSR_RESPONDER_CYCLE_CNT_EN
  logic [63:0] cnt;
  logic        hit_lo, hit_hi;

  assign hit_lo = (req_addr_i == CSR_MCYCLE);
  assign hit_hi = (req_addr_i == CSR_MCYCLEH);

  ibex_csr_responder_cnt u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_lo_i (do_write & hit_lo),
    .we_hi_i (do_write & hit_hi),
    .wdata_i (new_val),
    .cnt_o   (cnt)
  );
`endif

  // Address/op decode and old-value mux.
  always_comb begin
    old_val = '0;
    hit     = in_win;
    for (int i = 0; i < NumScratch; i++) begin
      if (in_win && win_off == 12'(i)) old_val = scratch_q[i];
    end
`ifdef IBEX_CSR_RESPONDER_CYCLE_CNT_EN
    if (hit_lo) old_val = cnt[31:0];
    if (hit_hi) old_val = cnt[63:32];
    hit = in_win | hit_lo | hit_hi;
`endif
    ro_viol  = (req_addr_i[11:10] == 2'b11) && (op != CSR_OP_READ);
    legal    = hit && !ro_viol && csr_op_defined(op);
    new_val  = csr_rmw(old_val, req_wdata_i, op);
    do_write = accept && legal && (op != CSR_OP_READ);
  end

  // Scratch update, committed in the acceptance cycle.
  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < NumScratch; i++) begin
      if (do_write && in_win && win_off == 12'(i)) scratch_d[i] = new_val;
    end
  end

  // Response payload: captured on acceptance, held otherwise.
  always_comb begin
    rsp_rdata_d   = rsp_rdata_q;
    rsp_illegal_d = rsp_illegal_q;
    if (accept) begin
      rsp_rdata_d   = legal ? old_val : 32'h0;
      rsp_illegal_d = ~legal;
    end
  end

  // FSM next state: RESP persists while responses keep streaming.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_IDLE: if (req_valid_i) state_d = RSP_RESP;
      RSP_RESP: if (rsp_ready_i) state_d = req_valid_i ? RSP_RESP : RSP_IDLE;
      default:  state_d = RSP_IDLE;
    endcase
  end

  // FSM outputs: accept-through when the pending response is consumed.
  always_comb begin
    req_ready_o = 1'b1;
    rsp_valid_o = 1'b0;
    if (state_q == RSP_RESP) begin
      req_ready_o = rsp_ready_i;
      rsp_valid_o = 1'b1;
    end
  end

  // State and CSR registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RSP_IDLE;
      scratch_q     <= {NumScratch{ScratchRstVal}};
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      scratch_q     <= scratch_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_ibex_csr_responder.sv
// Self-checking bench for ibex_csr_responder: directed sequences plus
// random traffic scored against a transaction-level model.
module tb_ibex_csr_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [11:0] req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  always #5 clk = ~clk;

  ibex_csr_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_op_i     (req_op),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_illegal_o(rsp_illegal)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: scratch array, 64-bit cycle count, expected responses.
  typedef struct {
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  logic [31:0]    m_scr [4];
  logic [63:0]    m_cyc;
  exp_t           q [$];

  function automatic logic [31:0] rmw(input logic [31:0] o, input logic [31:0] w,
                                      input logic [1:0] op);
    case (op)
      2'd1:    return w;
      2'd2:    return o | w;
      2'd3:    return o & ~w;
      default: return o;
    endcase
  endfunction

  // Model the request accepted this cycle; returns next counter value.
  function automatic logic [63:0] model_access(input logic [11:0] a, input logic [1:0] op,
                                               input logic [31:0] w);
    logic        in_win, is_lo, is_hi, legal;
    logic [31:0] old, nv;
    logic [63:0] nxt;
    exp_t        e;
    nxt    = m_cyc + 64'd1;
    in_win = (a >= 12'h7C0) && (a < 12'h7C4);
`ifdef IBEX_CSR_RESPONDER_CYCLE_CNT_EN
    is_lo  = (a == 12'hB00);
    is_hi  = (a == 12'hB80);
`else
    is_lo  = 1'b0;
    is_hi  = 1'b0;
`endif
    legal  = (in_win || is_lo || is_hi) && !((a >= 12'hC00) && (op != 2'd0));
    old    = in_win ? m_scr[a - 12'h7C0] : is_lo ? m_cyc[31:0] : m_cyc[63:32];
    e.rdata = legal ? old : 32'h0;
    e.ill   = !legal;
    q.push_back(e);
    if (legal && op != 2'd0) begin
      nv = rmw(old, w, op);
      if (in_win) m_scr[a - 12'h7C0] = nv;
      if (is_lo)  nxt = {m_cyc[63:32], nv};
      if (is_hi)  nxt = {nv, m_cyc[31:0]};
    end
    return nxt;
  endfunction

  // Monitor: check handshake and payload against the model every cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_scr[i] = 32'h0;
      m_cyc = 64'd0;
    end else begin
      logic [63:0] nxt;
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      chk("req_ready", 32'(req_ready), 32'(q.size() == 0 || rsp_ready));
      if (rsp_valid && q.size() != 0) begin
        chk("rdata", rsp_rdata, q[0].rdata);
        chk("illegal", 32'(rsp_illegal), 32'(q[0].ill));
        if (rsp_ready) void'(q.pop_front());
      end
      nxt = m_cyc + 64'd1;
      if (req_valid && req_ready) nxt = model_access(req_addr, req_op, req_wdata);
      m_cyc = nxt;
    end
  end

  task automatic put(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w,
                     input logic v, input logic r);
    req_addr  = a;
    req_op    = op;
    req_wdata = w;
    req_valid = v;
    rsp_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(12'h0, 2'd0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    int k;
    logic [11:0] a;
    rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    req_addr = '0; req_op = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_illegal", 32'(rsp_illegal), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back.
    put(12'h7C1, 2'd1, 32'hDEAD_BEEF, 1, 1);
    put(12'h7C1, 2'd0, 32'h0, 1, 1);
    idle(1);

    // Read-modify-write chain.
    put(12'h7C0, 2'd1, 32'h0000_00F0, 1, 1);
    put(12'h7C0, 2'd2, 32'h0000_000F, 1, 1);
    put(12'h7C0, 2'd3, 32'h0000_00F0, 1, 1);
    put(12'h7C0, 2'd0, 32'h0, 1, 1);
    idle(1);

    // Out-of-window and read-only writes, then confirm scratch untouched.
    put(12'h7C4, 2'd1, 32'h1111_1111, 1, 1);
    put(12'h7BF, 2'd1, 32'h2222_2222, 1, 1);
    put(12'hC00, 2'd1, 32'h3333_3333, 1, 1);
    for (int i = 0; i < 4; i++) put(12'h7C0 + 12'(i), 2'd0, 32'h0, 1, 1);
    idle(1);

    // Cycle counter: carry from the low word (illegal without the feature).
    put(12'hB00, 2'd1, 32'hFFFF_FFFE, 1, 1);
    idle(3);
    put(12'hB80, 2'd0, 32'h0, 1, 1);
    put(12'hB00, 2'd0, 32'h0, 1, 1);
    idle(1);

    // Backpressure: stall three cycles, then stream back-to-back.
    put(12'h7C2, 2'd1, 32'hA5A5_0001, 1, 0);
    put(12'h7C2, 2'd2, 32'h0000_0F00, 1, 0);
    put(12'h7C2, 2'd2, 32'h0000_0F00, 1, 0);
    put(12'h7C2, 2'd2, 32'h0000_0F00, 1, 0);
    put(12'h7C2, 2'd2, 32'h0000_0F00, 1, 1);
    put(12'h7C2, 2'd3, 32'hA500_0000, 1, 1);
    put(12'h7C2, 2'd0, 32'h0, 1, 1);
    idle(1);

    // Reset with a response pending.
    put(12'h7C3, 2'd1, 32'h5555_AAAA, 1, 0);
    put(12'h0, 2'd0, 32'h0, 0, 0);
    rst = 1'b1;
    put(12'h0, 2'd0, 32'h0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    put(12'h7C3, 2'd0, 32'h0, 1, 1);
    put(12'h7C1, 2'd0, 32'h0, 1, 1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 15));
      case (k)
        0:       a = 12'h7BF;
        1:       a = 12'h7C4;
        2:       a = 12'hC00 + 12'($urandom_range(0, 3));
        3:       a = 12'hB00;
        4:       a = 12'hB80;
        5:       a = 12'($urandom);
        default: a = 12'h7C0 + 12'($urandom_range(0, 3));
      endcase
      put(a, 2'($urandom), $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0));
    end

    // Drain with a bounded wait.
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
